// File: rtl/tp_capture.sv
// Test-point capture: mask/value trigger into a circular RAM
// with a pre-trigger window and registered logical readout.
module tp_capture #(
    parameter int  DW    = 32,
    parameter int  DEPTH = 256,
    parameter int  PRE   = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          MCLKx2,
    input  logic          iRESET_n,
    input  logic [DW-1:0] iPROBE,
    input  logic          iARM,
    input  logic          iABORT,
    input  logic [DW-1:0] iTRIG_MASK,
    input  logic [DW-1:0] iTRIG_VAL,
    input  logic          iTRIG_EDGE,
    output logic [2:0]    oSTATE,
    output logic          oDONE,
    output logic [AW-1:0] oTRIG_ADDR,
    input  logic [AW-1:0] iRD_ADDR,
    output logic [DW-1:0] oRD_DATA
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int          POST_N    = DEPTH - PRE - 1;
    localparam logic [AW-1:0] PRE_A     = AW'(PRE);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE > 0 ? PRE - 1 : 0);
    localparam logic [AW-1:0] POST_LAST = AW'(POST_N > 0 ? POST_N - 1 : 0);

    state_t          state;
    state_t          state_n;
    logic [AW-1:0]   wp;
    logic [AW-1:0]   cnt;
    logic            prev_match;
    logic            match;
    logic            hit;
    logic            we;
    logic            start;
    logic            take;
    logic            finish;
    logic [AW-1:0]   rd_phys;
    logic [DW-1:0]   mem [DEPTH];

    assign match   = ~|((iPROBE ^ iTRIG_VAL) & iTRIG_MASK);
    assign hit     = iTRIG_EDGE ? (match & ~prev_match) : match;
    assign rd_phys = oTRIG_ADDR - PRE_A + iRD_ADDR;
    assign oSTATE  = state;

    always_ff @(posedge MCLKx2 or negedge iRESET_n) begin
        if (!iRESET_n) state <= S_IDLE;
        else           state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (iABORT)
            state_n = S_IDLE;
        else if (start)
            state_n = (PRE == 0) ? S_ARMED : S_PRE;
        else if (finish)
            state_n = S_DONE;
        else if (take)
            state_n = S_POST;
        else if (state == S_PRE && cnt == PRE_LAST)
            state_n = S_ARMED;
    end

    // Abort suppresses every action, including the write of that cycle.
    always_comb begin
        we     = 1'b0;
        start  = 1'b0;
        take   = 1'b0;
        finish = 1'b0;
        if (!iABORT) begin
            unique case (state)
                S_IDLE, S_DONE: start = iARM;
                S_PRE:          we = 1'b1;
                S_ARMED: begin
                    we     = 1'b1;
                    take   = hit;
                    finish = hit && (POST_N == 0);
                end
                S_POST: begin
                    we     = 1'b1;
                    finish = (cnt == POST_LAST);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge MCLKx2 or negedge iRESET_n) begin
        if (!iRESET_n) begin
            wp         <= '0;
            cnt        <= '0;
            prev_match <= 1'b1;
            oDONE      <= 1'b0;
            oTRIG_ADDR <= '0;
        end else if (iABORT) begin
            oDONE <= 1'b0;
        end else begin
            if (start) begin
                wp         <= '0;
                cnt        <= '0;
                prev_match <= 1'b1;
                oDONE      <= 1'b0;
            end
            if (we)
                wp <= wp + AW'(1);
            if (state == S_PRE || state == S_ARMED)
                prev_match <= match;
            if (state == S_PRE || state == S_POST)
                cnt <= cnt + AW'(1);
            if (take) begin
                oTRIG_ADDR <= wp;
                cnt        <= '0;
            end
            if (finish)
                oDONE <= 1'b1;
        end
    end

    always_ff @(posedge MCLKx2) begin
        if (we) mem[wp] <= iPROBE;
    end

    always_ff @(posedge MCLKx2 or negedge iRESET_n) begin
        if (!iRESET_n) oRD_DATA <= '0;
        else           oRD_DATA <= mem[rd_phys];
    end

endmodule

// File: tb/tb_tp_capture.sv
// Directed bench for tp_capture: DW=8, DEPTH=16, PRE=4 plus a PRE=0 instance.
// Probe is a counter advanced at each falling edge while run is set.
module tb_tp_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] probe;
    logic       run;
    logic [7:0] mask, val;
    logic       edge_m;
    logic       arm0, abort0, arm1, abort1;
    logic [3:0] rd0, rd1;
    logic [2:0] st0, st1;
    logic       done0, done1;
    logic [3:0] trig0, trig1;
    logic [7:0] dat0, dat1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tp_capture #(.DW(8), .DEPTH(16), .PRE(4)) u0 (
        .MCLKx2(clk), .iRESET_n(rst_n), .iPROBE(probe),
        .iARM(arm0), .iABORT(abort0),
        .iTRIG_MASK(mask), .iTRIG_VAL(val), .iTRIG_EDGE(edge_m),
        .oSTATE(st0), .oDONE(done0), .oTRIG_ADDR(trig0),
        .iRD_ADDR(rd0), .oRD_DATA(dat0)
    );

    tp_capture #(.DW(8), .DEPTH(16), .PRE(0)) u1 (
        .MCLKx2(clk), .iRESET_n(rst_n), .iPROBE(probe),
        .iARM(arm1), .iABORT(abort1),
        .iTRIG_MASK(mask), .iTRIG_VAL(val), .iTRIG_EDGE(edge_m),
        .oSTATE(st1), .oDONE(done1), .oTRIG_ADDR(trig1),
        .iRD_ADDR(rd1), .oRD_DATA(dat1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (run) probe = probe + 8'd1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_st(input int which, input logic [2:0] want,
                           input int budget, input string tag);
        int k;
        k = 0;
        while (((which == 0) ? st0 : st1) !== want && k < budget) begin
            step();
            k++;
        end
        chk(tag, (which == 0) ? st0 : st1, want);
    endtask

    task automatic arm_u0(input logic [7:0] p);
        probe = p;
        arm0  = 1'b1;
        step();
        arm0  = 1'b0;
    endtask

    task automatic read_all(input logic [7:0] first, input string tag);
        for (int i = 0; i < 16; i++) begin
            rd0 = 4'(i);
            step();
            chk(tag, dat0, first + 8'(i));
        end
    endtask

    initial begin
        rst_n = 1'b0; probe = '0; run = 1'b0;
        mask = '0; val = '0; edge_m = 1'b0;
        arm0 = 0; abort0 = 0; arm1 = 0; abort1 = 0;
        rd0 = '0; rd1 = '0;
        steps(2);
        chk("rst_state", st0, 3'd0);
        chk("rst_done", done0, 1'b0);
        chk("rst_trig", trig0, 4'd0);
        chk("rst_rd", dat0, 8'd0);
        rst_n = 1'b1;
        step();

        // level trigger
        mask = 8'hFF; val = 8'h20; edge_m = 1'b0; run = 1'b1;
        arm_u0(8'h10);
        chk("lvl_pre", st0, 3'd1);
        wait_st(0, 3'd2, 10, "lvl_armed");
        wait_st(0, 3'd3, 30, "lvl_post");
        wait_st(0, 3'd4, 30, "lvl_done");
        chk("lvl_trig", trig0, 4'd15);
        read_all(8'h1C, "lvl_rd");
        chk("lvl_done_held", done0, 1'b1);

        // edge trigger on a constant matching probe
        run = 1'b0;
        mask = 8'h0F; val = 8'h05; edge_m = 1'b1;
        arm_u0(8'h05);
        steps(10);
        chk("edge_notrig", st0, 3'd2);
        probe = 8'h06;
        step();
        chk("edge_06", st0, 3'd2);
        probe = 8'h15;
        step();
        chk("edge_hit", st0, 3'd3);
        run = 1'b1;
        wait_st(0, 3'd4, 30, "edge_done");
        rd0 = 4'd4; step(); chk("edge_rd4", dat0, 8'h15);
        rd0 = 4'd3; step(); chk("edge_rd3", dat0, 8'h06);
        rd0 = 4'd0; step(); chk("edge_rd0", dat0, 8'h05);

        // long ARMED phase, trigger address wraps
        mask = 8'hFF; val = 8'h80; edge_m = 1'b0;
        arm_u0(8'h63);
        wait_st(0, 3'd3, 60, "wrap_post");
        wait_st(0, 3'd4, 30, "wrap_done");
        chk("wrap_trig", trig0, 4'd12);
        read_all(8'h7C, "wrap_rd");

        // abort in POST, then re-arm
        val = 8'h90;
        arm_u0(8'h88);
        wait_st(0, 3'd3, 30, "abt_post");
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        chk("abt_state", st0, 3'd0);
        chk("abt_done", done0, 1'b0);
        val = 8'h40;
        arm_u0(8'h30);
        wait_st(0, 3'd4, 60, "abt2_done");
        chk("abt2_trig", trig0, 4'd15);
        read_all(8'h3C, "abt2_rd");
        chk("abt2_doneflag", done0, 1'b1);

        // arm and abort together
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        chk("aa_idle", st0, 3'd0);
        arm0 = 1'b1; abort0 = 1'b1;
        step();
        arm0 = 1'b0; abort0 = 1'b0;
        chk("aa_same", st0, 3'd0);
        step();
        chk("aa_stay", st0, 3'd0);

        // asynchronous reset while ARMED
        val = 8'hFF;
        arm_u0(8'h00);
        wait_st(0, 3'd2, 10, "ar_armed");
        rst_n = 1'b0;
        #1;
        chk("ar_state", st0, 3'd0);
        chk("ar_done", done0, 1'b0);
        chk("ar_trig", trig0, 4'd0);
        chk("ar_rd", dat0, 8'd0);
        step();
        rst_n = 1'b1;
        step();

        // PRE=0 instance
        val = 8'h30;
        probe = 8'h2F;
        arm1 = 1'b1;
        step();
        arm1 = 1'b0;
        chk("p0_armed", st1, 3'd2);
        step();
        chk("p0_post", st1, 3'd3);
        wait_st(1, 3'd4, 30, "p0_done");
        chk("p0_trig", trig1, 4'd0);
        chk("p0_doneflag", done1, 1'b1);
        rd1 = 4'd0;
        step();
        chk("p0_rd0", dat1, 8'h30);
        rd1 = 4'd15;
        #1;
        chk("p0_lat", dat1, 8'h30);
        step();
        chk("p0_rd15", dat1, 8'h3F);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tp_capture.md
Name: tp_capture

Overview:
- Parametrised successor to the team's passive test-point probe bundle.
- Samples a DW-bit probe vector every MCLKx2 cycle into a DEPTH-entry circular on-chip RAM.
- Stops after a mask/value trigger plus a configurable pre-trigger window.
- Provides a registered readout port, so debug snapshots are readable over the control interface and SignalTap is not needed.

Parameters:
- DW, 32, probe vector width (1..64)
- DEPTH, 256, capture RAM entries; power of two, 8..4096
- AW, log2(DEPTH), address width (derived, not overridden)
- PRE, 64, samples kept before the trigger sample; 0..DEPTH-1

Ports:
- MCLKx2  in  1  capture and control clock
- iRESET_n  in  1  asynchronous active-low reset
- iPROBE  in  DW  probe vector, sampled every cycle while capturing
- iARM  in  1  single-cycle pulse; starts a capture
- iABORT  in  1  single-cycle pulse; cancels the capture and returns to IDLE
- iTRIG_MASK  in  DW  compare mask; a 1 bit is compared
- iTRIG_VAL  in  DW  compare value
- iTRIG_EDGE  in  1  0 = level trigger, 1 = edge trigger (match now, no match on previous sample)
- oSTATE  out  3  0=IDLE, 1=PRE, 2=ARMED, 3=POST, 4=DONE
- oDONE  out  1  high in DONE
- oTRIG_ADDR  out  AW  physical RAM address of the trigger sample
- iRD_ADDR  in  AW  logical read index; 0 = oldest sample, PRE = trigger sample
- oRD_DATA  out  DW  registered read data

Behaviour:
- Reset (async, iRESET_n low):
  - oSTATE=IDLE, oDONE=0, oTRIG_ADDR=0, oRD_DATA=0.
  - Write pointer wp=0, sample counter cnt=0, prev_match=1.
  - RAM contents undefined.
- match = ((iPROBE ^ iTRIG_VAL) & iTRIG_MASK) == 0.
- hit = match when iTRIG_EDGE=0; match & ~prev_match when iTRIG_EDGE=1.
- prev_match <= match every cycle in PRE and ARMED.
- IDLE or DONE with iARM=1:
  - wp<=0, cnt<=0, prev_match<=1, oDONE<=0.
  - Next state is PRE, or ARMED if PRE==0.
  - Sampling starts the following cycle.
- PRE:
  - Each cycle: RAM[wp]<=iPROBE, wp<=wp+1 (mod DEPTH), cnt<=cnt+1.
  - The trigger is ignored.
  - After PRE samples are written, go to ARMED.
- ARMED:
  - Writes every cycle and wraps freely, so the buffer always holds the latest samples.
  - On hit: the current sample is written at wp, oTRIG_ADDR<=wp, cnt<=0, go to POST.
- POST:
  - Writes every cycle.
  - After DEPTH-PRE-1 further samples, go to DONE; writes stop and oDONE<=1.
  - If DEPTH-PRE-1==0, go straight from the hit to DONE.
- DONE: holds the buffer until iARM or iABORT.
- iABORT has priority over every other event in every state. Next state is IDLE, oDONE<=0, and buffer contents are kept.
- iARM in PRE, ARMED or POST is ignored. iARM and iABORT in the same cycle: abort wins.
- Readout:
  - Physical address = (oTRIG_ADDR - PRE + iRD_ADDR) mod DEPTH, using AW-bit wrap arithmetic.
  - oRD_DATA updates 1 cycle after iRD_ADDR.
  - Valid only in DONE; outside DONE the data is undefined but the port still operates.
- A read of a physical address in the same cycle as a write to it returns the old data.
- The RAM is inferable as simple dual-port block RAM: one write port, one registered read port.

Test Plan:
(DW=8, DEPTH=16, PRE=4; iPROBE = free-running 8-bit counter incrementing each cycle.)
- Level trigger: mask=FF, val=20, arm at probe=10 → state sequence PRE→ARMED→POST→DONE. Reads 0..15 return 1C..2B; index 4 = 20; oDONE=1 stays set.
- Edge trigger: mask=0F, val=05 with a constant probe 05 present at arm → no trigger. Probe then changes to 06, then 15 → trigger on 15; read index 4 = 15.
- Wrap: trigger at probe=80 after more than 16 cycles in ARMED → oTRIG_ADDR wraps correctly. Reads return 7C..8B contiguous across the physical wrap.
- Abort in POST, then arm again → oSTATE=0 one cycle after abort and oDONE=0. A second capture with val=40 completes with reads 3C..4B.
- Arm and abort in the same cycle from IDLE → remains IDLE. Reset asserted mid-ARMED → all outputs return to their reset values immediately (asynchronous).
- PRE=0 build: arm, trigger at 30 → PRE state skipped; read 0 = 30, read 15 = 3F. Read latency is exactly 1 cycle.
